// File: rtl/apb_router_pkg.sv
// Shared types, defaults and the slave decode helper for the APB quad write router.
package apb_router_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_SLAVES = 4;
    localparam int ADDR_W_MAX = 64;

    typedef logic [1:0] slave_idx_t;

    // The slave index is the top two bits of an addr_w-wide address.
    // The address arrives zero-extended to ADDR_W_MAX bits.
    function automatic slave_idx_t decode_slave(input logic [ADDR_W_MAX-1:0] addr,
                                                input int unsigned           addr_w);
        return slave_idx_t'(addr >> (addr_w - 2));
    endfunction

endpackage

// File: rtl/apb_out_port.sv
// One registered output port of the router.
// It latches the request on a hit and pulses wr for one cycle per accepted write.
module apb_out_port
    import apb_router_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit,
    input  logic              wr_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            wr <= hit && wr_in;
            if (hit) begin
                addr <= addr_in;
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/apb_quad_write_router.sv
// Single-master to four-slave request router.
// The top address bits pick one slave, and the request reaches it through a single register stage.
module apb_quad_write_router
    import apb_router_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              wr_in,
    input  logic              sel,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_out1,
    output logic              wr_out2,
    output logic              wr_out3,
    output logic              wr_out4,
    output logic [ADDR_W-1:0] addr_out1,
    output logic [ADDR_W-1:0] addr_out2,
    output logic [ADDR_W-1:0] addr_out3,
    output logic [ADDR_W-1:0] addr_out4,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic [DATA_W-1:0] data_out4
);

    slave_idx_t            idx;
    logic [NUM_SLAVES-1:0] hit;

    assign idx = decode_slave(ADDR_W_MAX'(addr_in), ADDR_W);

    // sel gates the decode, so an unknown address while idle cannot produce a hit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = sel && (idx == slave_idx_t'(i));
        end
    end

    apb_out_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
        .clk(clk), .rst(rst), .hit(hit[0]), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in),
        .wr(wr_out1), .addr(addr_out1), .data(data_out1)
    );

    apb_out_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port2 (
        .clk(clk), .rst(rst), .hit(hit[1]), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in),
        .wr(wr_out2), .addr(addr_out2), .data(data_out2)
    );

    apb_out_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port3 (
        .clk(clk), .rst(rst), .hit(hit[2]), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in),
        .wr(wr_out3), .addr(addr_out3), .data(data_out3)
    );

    apb_out_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port4 (
        .clk(clk), .rst(rst), .hit(hit[3]), .wr_in(wr_in),
        .addr_in(addr_in), .data_in(data_in),
        .wr(wr_out4), .addr(addr_out4), .data(data_out4)
    );

endmodule

// File: tb/tb_apb_quad_write_router.sv
// Bench for apb_quad_write_router.
// It applies table-driven vectors with hand-computed port state, then directed reset and idle sequences.
module tb_apb_quad_write_router;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_in;
    logic          wr_in;
    logic          sel;
    logic [DW-1:0] data_in;
    logic          wr_out1, wr_out2, wr_out3, wr_out4;
    logic [AW-1:0] addr_out1, addr_out2, addr_out3, addr_out4;
    logic [DW-1:0] data_out1, data_out2, data_out3, data_out4;

    apb_quad_write_router #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .wr_in(wr_in), .sel(sel), .data_in(data_in),
        .wr_out1(wr_out1), .wr_out2(wr_out2), .wr_out3(wr_out3), .wr_out4(wr_out4),
        .addr_out1(addr_out1), .addr_out2(addr_out2), .addr_out3(addr_out3), .addr_out4(addr_out4),
        .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3), .data_out4(data_out4)
    );

    always #5 clk = ~clk;

    logic [3:0]    wr_all;
    logic [31:0]   addr_all;
    logic [127:0]  data_all;
    assign wr_all   = {wr_out4, wr_out3, wr_out2, wr_out1};
    assign addr_all = {addr_out4, addr_out3, addr_out2, addr_out1};
    assign data_all = {data_out4, data_out3, data_out2, data_out1};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] ew,
                               input logic [31:0] ea, input logic [127:0] ed);
        check({tag, " wr"},   128'(wr_all),   128'(ew));
        check({tag, " addr"}, 128'(addr_all), 128'(ea));
        check({tag, " data"}, data_all,       ed);
    endtask

    typedef struct {
        logic          sel;
        logic          wr;
        logic [7:0]    addr;
        logic [31:0]   data;
        logic [3:0]    ew;
        logic [31:0]   ea;
        logic [127:0]  ed;
    } vec_t;

    vec_t vt[10];

    initial begin
        // Expected state is packed as {port4, port3, port2, port1}.
        vt[0] = '{1'b1, 1'b1, 8'h45, 32'hDEADBEEF, 4'b0010, 32'h00_00_45_00,
                  128'h00000000_00000000_DEADBEEF_00000000};
        vt[1] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 4'b0000, 32'h00_00_45_00,
                  128'h00000000_00000000_DEADBEEF_00000000};
        vt[2] = '{1'b1, 1'b1, 8'h01, 32'h00000011, 4'b0001, 32'h00_00_45_01,
                  128'h00000000_00000000_DEADBEEF_00000011};
        vt[3] = '{1'b1, 1'b1, 8'h41, 32'h00000022, 4'b0010, 32'h00_00_41_01,
                  128'h00000000_00000000_00000022_00000011};
        vt[4] = '{1'b1, 1'b1, 8'h81, 32'h00000033, 4'b0100, 32'h00_81_41_01,
                  128'h00000000_00000033_00000022_00000011};
        vt[5] = '{1'b1, 1'b1, 8'hC1, 32'h00000044, 4'b1000, 32'hC1_81_41_01,
                  128'h00000044_00000033_00000022_00000011};
        vt[6] = '{1'b1, 1'b0, 8'h82, 32'h00000055, 4'b0000, 32'hC1_82_41_01,
                  128'h00000044_00000055_00000022_00000011};
        vt[7] = '{1'b1, 1'b1, 8'h3F, 32'h000000AA, 4'b0001, 32'hC1_82_41_3F,
                  128'h00000044_00000055_00000022_000000AA};
        vt[8] = '{1'b1, 1'b1, 8'h00, 32'h000000BB, 4'b0001, 32'hC1_82_41_00,
                  128'h00000044_00000055_00000022_000000BB};
        vt[9] = '{1'b0, 1'b1, 8'hxx, 32'h000000FF, 4'b0000, 32'hC1_82_41_00,
                  128'h00000044_00000055_00000022_000000BB};

        // Reset held with an active write request on the inputs.
        rst = 1'b1; sel = 1'b1; wr_in = 1'b1; addr_in = 8'h45; data_in = 32'hDEADBEEF;
        #3 rst = 1'b0;
        #1 check_state("reset_async", 4'b0, 32'h0, 128'h0);
        repeat (3) @(posedge clk);
        #1 check_state("reset_held", 4'b0, 32'h0, 128'h0);
        @(negedge clk);
        rst = 1'b1; sel = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = vt[i].sel; wr_in = vt[i].wr; addr_in = vt[i].addr; data_in = vt[i].data;
            @(posedge clk);
            #1 check_state($sformatf("vec%0d", i), vt[i].ew, vt[i].ea, vt[i].ed);
        end

        // The write to port 2 must be a single-cycle pulse, and its addr/data must hold afterwards.
        @(negedge clk);
        sel = 1'b1; wr_in = 1'b1; addr_in = 8'h45; data_in = 32'hDEADBEEF;
        @(posedge clk);
        #1 check_state("single_wr", 4'b0010, 32'hC1_82_45_00,
                       128'h00000044_00000055_DEADBEEF_000000BB);
        @(negedge clk);
        sel = 1'b0;
        @(posedge clk);
        #1 check_state("single_wr_after", 4'b0000, 32'hC1_82_45_00,
                       128'h00000044_00000055_DEADBEEF_000000BB);

        // While idle, random inputs with sel low must not change any port.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = 1'b0; wr_in = 1'($urandom_range(1)); addr_in = 8'($urandom); data_in = $urandom;
            @(posedge clk);
            #1 check_state($sformatf("idle%0d", i), 4'b0000, 32'hC1_82_45_00,
                           128'h00000044_00000055_DEADBEEF_000000BB);
        end

        // Reset asserted mid-cycle clears a registered strobe without a clock edge.
        @(negedge clk);
        sel = 1'b1; wr_in = 1'b1; addr_in = 8'h45; data_in = 32'h00001234;
        @(posedge clk);
        #1 check("midrst_pre wr", 128'(wr_all), 128'(4'b0010));
        #2 rst = 1'b0;
        #1 check_state("midrst_clear", 4'b0, 32'h0, 128'h0);

        // A port 4 write pending when reset hits must never produce a strobe.
        @(negedge clk);
        rst = 1'b1; sel = 1'b1; wr_in = 1'b1; addr_in = 8'hF0; data_in = 32'h00000099;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check_state("rst_traffic", 4'b0, 32'h0, 128'h0);
        @(negedge clk);
        sel = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 check_state("rst_release_nostale", 4'b0, 32'h0, 128'h0);

        // After the reset the router accepts a new write to port 4 normally.
        @(negedge clk);
        sel = 1'b1; wr_in = 1'b1; addr_in = 8'hF0; data_in = 32'h00000099;
        @(posedge clk);
        #1 check_state("post_rst_wr", 4'b1000, 32'hF0_00_00_00,
                       128'h00000099_00000000_00000000_00000000);
        @(negedge clk);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
